mips_register_file: RTL

//  Architectural 32x32 register file for the single-cycle MIPS datapath.

---
 rtl/mips_register_file_pkg.sv | 29 ++
 rtl/mips_register_file_reg32_cell.sv | 21 ++
 rtl/mips_register_file.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_register_file_pkg.sv
// Shared constants and read-source selection helper for the MIPS register file.
// Register indices and widths used by the datapath around the register file.
package mips_register_file_pkg;

  localparam int         REG_COUNT = 32;
  localparam int         DATA_W    = 32;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_RA    = 5'd31;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_STORED = 2'd2
  } rd_src_e;

  // $zero wins over forwarding, forwarding wins over stored contents.
  function automatic rd_src_e rd_src_sel(input logic idx_is_zero, input logic bypass_hit);
    rd_src_e sel;
    if (idx_is_zero) begin
      sel = SRC_ZERO;
    end else if (bypass_hit) begin
      sel = SRC_BYPASS;
    end else begin
      sel = SRC_STORED;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_register_file_reg32_cell.sv
// One architectural register: async active-low clear, synchronous write enable.
module reg32_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Storage; an unknown enable leaves the contents intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_en === 1'b1) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: two combinational read ports with optional
// same-cycle write forwarding, one synchronous write port, $zero hardwired.
module mips_register_file
  import mips_register_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int   DEPTH  = 2 ** ADDR_W;
  localparam logic BYP_EN = (BYPASS != 0) ? 1'b1 : 1'b0;

  logic [DATA_W-1:0] regs_s [DEPTH];
  logic [DEPTH-1:1]  wr_en_s;
  logic [DATA_W-1:0] mux1_s;
  logic [DATA_W-1:0] mux2_s;
  logic              hit1_s;
  logic              hit2_s;
  rd_src_e           src1_s;
  rd_src_e           src2_s;

  // Write decoder: one-hot on write_reg, qualified by reg_write; index 0 has no cell.
  always_comb begin
    wr_en_s = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_en_s[i] = (write_reg == ADDR_W'(i)) & reg_write;
    end
  end

  assign regs_s[0] = '0;

  generate
    for (genvar g = 1; g < DEPTH; g++) begin : g_cell
      reg32_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en_s[g]),
        .d     (write_data),
        .q     (regs_s[g])
      );
    end
  endgenerate

  assign mux1_s = regs_s[read_reg1];
  assign mux2_s = regs_s[read_reg2];

  // Forwarding is suppressed during reset so the read ports show zero there.
  assign hit1_s = BYP_EN & rst_n & reg_write & (write_reg == read_reg1);
  assign hit2_s = BYP_EN & rst_n & reg_write & (write_reg == read_reg2);

  assign src1_s = rd_src_sel(read_reg1 == '0, hit1_s);
  assign src2_s = rd_src_sel(read_reg2 == '0, hit2_s);

  // Read port 1 source select.
  always_comb begin
    read_data1 = '0;
    case (src1_s)
      SRC_ZERO:   read_data1 = '0;
      SRC_BYPASS: read_data1 = write_data;
      SRC_STORED: read_data1 = mux1_s;
      default:    read_data1 = '0;
    endcase
  end

  // Read port 2 source select.
  always_comb begin
    read_data2 = '0;
    case (src2_s)
      SRC_ZERO:   read_data2 = '0;
      SRC_BYPASS: read_data2 = write_data;
      SRC_STORED: read_data2 = mux2_s;
      default:    read_data2 = '0;
    endcase
  end

endmodule
